led_pio_sequencer: RTL and testbench

Avalon-MM master that drives the 8-bit LED PIO slave (data register at offset 0) from a self-timed pattern engine. Provides static, rotate and bounce patterns, advanced by a programmable prescaler. A one-shot software write port shares the same PIO slave. Sits between the SOPC control registers/CPU-side glue and the LED PIO s1 port.

---
 rtl/led_pio_sequencer_if.sv | 25 ++
 rtl/led_pio_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_led_pio_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pio_sequencer_if.sv
// Avalon-MM write-only bundle between the LED sequencer (master)
// and the LED PIO s1 port (slave).
interface led_pio_sequencer_if;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_waitrequest
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_waitrequest
    );
endinterface

// File: rtl/led_pio_sequencer.sv
// LED PIO sequencer: self-timed pattern engine plus software write port
// sharing one Avalon-MM master. Optional hold feature: LED_SEQ_HOLD_EN.
module led_pio_sequencer #(
    parameter int         DIV_W    = 24,
    parameter logic [1:0] PIO_ADDR = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_pattern,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             sw_req,
    input  logic [7:0]       sw_data,
`ifdef LED_SEQ_HOLD_EN
    input  logic             sw_release,
`endif
    output logic             sw_ack,
    output logic [7:0]       cur_pattern,
    output logic             busy,
    led_pio_sequencer_if.master avm
);

    typedef enum logic [1:0] {
        IDLE,
        WR_SW,
        WR_SEQ
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] cnt;
    logic             tick;
    logic             tick_set;
    logic             tick_pend;
    logic [1:0]       mode_q;
    logic [7:0]       pat_q;
    logic             reload_pend;
    logic             reload;
    logic [7:0]       seq;
    logic [7:0]       seq_nx;
    logic             dir_left;
    logic             dir_nx;
    logic [7:0]       wdata_q;
    logic             sw_go;
    logic             seq_start;
    logic             wr_done;

    assign tick = enable && (cnt >= cfg_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Config edits are remembered until the next tick consumes them.
    assign reload = reload_pend ||
                    (cfg_mode != mode_q) ||
                    (cfg_pattern != pat_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= 2'd0;
            pat_q       <= 8'd0;
            reload_pend <= 1'b0;
        end else begin
            mode_q      <= cfg_mode;
            pat_q       <= cfg_pattern;
            reload_pend <= reload && !tick;
        end
    end

    always_comb begin
        seq_nx = seq;
        dir_nx = dir_left;
        if (reload) begin
            seq_nx = (cfg_mode == 2'd0) ? 8'd0 : cfg_pattern;
            dir_nx = 1'b1;
        end else begin
            unique case (cfg_mode)
                2'd0: seq_nx = 8'd0;
                2'd1: seq_nx = cfg_pattern;
                2'd2: seq_nx = {seq[6:0], seq[7]};
                2'd3: begin
                    if (dir_left) begin
                        seq_nx = {seq[6:0], 1'b0};
                        dir_nx = !seq_nx[7];
                    end else begin
                        seq_nx = {1'b0, seq[7:1]};
                        dir_nx = seq_nx[0];
                    end
                end
                default: seq_nx = seq;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq      <= 8'd0;
            dir_left <= 1'b1;
        end else if (tick) begin
            seq      <= seq_nx;
            dir_left <= dir_nx;
        end
    end

    // The ack cycle masks sw_req so one request yields one write.
    assign sw_go     = sw_req && !sw_ack;
    assign seq_start = (state == IDLE) && !sw_go && tick_pend;
    assign wr_done   = (state != IDLE) && !avm.m_waitrequest;

`ifdef LED_SEQ_HOLD_EN
    logic hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= 1'b0;
        end else if (wr_done && state == WR_SW) begin
            hold <= 1'b1;
        end else if (sw_release) begin
            hold <= 1'b0;
        end
    end

    assign tick_set = tick && !hold;
`else
    assign tick_set = tick;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_pend <= 1'b0;
        end else if (tick_set) begin
            tick_pend <= 1'b1;
        end else if (seq_start) begin
            tick_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx           = state;
        busy               = 1'b0;
        avm.m_address      = PIO_ADDR;
        avm.m_chipselect   = 1'b0;
        avm.m_write_n      = 1'b1;
        avm.m_writedata    = 32'd0;
        unique case (state)
            IDLE: begin
                if (sw_go) begin
                    state_nx = WR_SW;
                end else if (tick_pend) begin
                    state_nx = WR_SEQ;
                end
            end
            WR_SW, WR_SEQ: begin
                busy             = 1'b1;
                avm.m_chipselect = 1'b1;
                avm.m_write_n    = 1'b0;
                avm.m_writedata  = {24'd0, wdata_q};
                if (!avm.m_waitrequest) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write data is latched every idle cycle, so it is frozen on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdata_q     <= 8'd0;
            cur_pattern <= 8'd0;
            sw_ack      <= 1'b0;
        end else begin
            sw_ack <= wr_done && (state == WR_SW);
            if (state == IDLE) begin
                wdata_q <= sw_go ? sw_data : seq;
            end
            if (wr_done) begin
                cur_pattern <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Scoreboard bench for led_pio_sequencer: expected LED writes are
// queued by stimulus and consumed by a bus monitor/slave model.
`timescale 1ns/1ps
module tb_led_pio_sequencer;
    localparam int         DIV_W    = 24;
    localparam logic [1:0] PIO_ADDR = 2'd0;
`ifdef LED_SEQ_HOLD_EN
    localparam bit SW_MIX = 1'b0;
`else
    localparam bit SW_MIX = 1'b1;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [1:0]       cfg_mode = 2'd0;
    logic [7:0]       cfg_pattern = 8'd0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             sw_req = 1'b0;
    logic [7:0]       sw_data = 8'd0;
    logic             sw_ack;
    logic [7:0]       cur_pattern;
    logic             busy;
`ifdef LED_SEQ_HOLD_EN
    logic             sw_release = 1'b0;
`endif

    led_pio_sequencer_if avm();

    led_pio_sequencer #(
        .DIV_W   (DIV_W),
        .PIO_ADDR(PIO_ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_mode   (cfg_mode),
        .cfg_pattern(cfg_pattern),
        .cfg_div    (cfg_div),
        .sw_req     (sw_req),
        .sw_data    (sw_data),
`ifdef LED_SEQ_HOLD_EN
        .sw_release (sw_release),
`endif
        .sw_ack     (sw_ack),
        .cur_pattern(cur_pattern),
        .busy       (busy),
        .avm        (avm.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] sw_q[$];
    logic [7:0] seq_q[$];

    bit          armed = 0;
    int          remaining = 0;
    logic [31:0] wd_cap = 0;
    bit          pend_chk = 0;
    logic [7:0]  pend_data = 0;
    int          seq_done = 0;
    int          last_seq_cyc = 0;
    int          last_sw_cyc = 0;
    int          prev_seq_cyc = -1;
    int          exp_period = 0;
    int          max_stall = 0;
    int          fixed_stall = -1;
    bit          force_stall = 0;

    task automatic check_eq(input string name,
                            input logic [31:0] act,
                            input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input int act, input int req);
        checks++;
        errors++;
        $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    always @(posedge clk) cyc++;

    // Bus monitor doubling as the PIO slave: inserts wait states,
    // and checks each completed write one cycle later.
    always @(negedge clk) begin
        if (reset) begin
            armed              = 0;
            pend_chk           = 0;
            avm.m_waitrequest  = 1'b0;
        end else begin
            if (pend_chk) begin
                pend_chk = 0;
                check_eq("strobe_drop", {31'd0, avm.m_chipselect}, 32'd0);
                check_eq("cur_pattern", {24'd0, cur_pattern},
                         {24'd0, pend_data});
                if (sw_ack) begin
                    last_sw_cyc = cyc;
                    if (sw_q.size() == 0)
                        fail("unexpected_sw_write", pend_data, -1);
                    else
                        check_eq("sw_write", {24'd0, pend_data},
                                 {24'd0, sw_q.pop_front()});
                end else begin
                    last_seq_cyc = cyc;
                    if (seq_q.size() == 0)
                        fail("unexpected_seq_write", pend_data, -1);
                    else
                        check_eq("seq_write", {24'd0, pend_data},
                                 {24'd0, seq_q.pop_front()});
                    if (exp_period > 0 && prev_seq_cyc >= 0)
                        check_eq("tick_period", cyc - prev_seq_cyc,
                                 exp_period);
                    prev_seq_cyc = cyc;
                    seq_done++;
                end
            end else begin
                check_eq("ack_idle", {31'd0, sw_ack}, 32'd0);
            end

            if (avm.m_chipselect) begin
                check_eq("write_n", {31'd0, avm.m_write_n}, 32'd0);
                check_eq("address", {30'd0, avm.m_address},
                         {30'd0, PIO_ADDR});
                check_eq("busy_wr", {31'd0, busy}, 32'd1);
                if (!armed) begin
                    armed  = 1;
                    wd_cap = avm.m_writedata;
                    if (force_stall)
                        remaining = 1;
                    else if (fixed_stall >= 0)
                        remaining = fixed_stall;
                    else
                        remaining = $urandom_range(max_stall, 0);
                end else begin
                    check_eq("wdata_stable", avm.m_writedata, wd_cap);
                    if (remaining > 0) remaining--;
                end
                avm.m_waitrequest = force_stall || (remaining > 0);
                if (!avm.m_waitrequest) begin
                    check_eq("wdata_hi", {8'd0, wd_cap[31:8]}, 32'd0);
                    pend_chk  = 1;
                    pend_data = wd_cap[7:0];
                    armed     = 0;
                end
            end else begin
                check_eq("write_n_idle", {31'd0, avm.m_write_n}, 32'd1);
                check_eq("busy_idle", {31'd0, busy}, 32'd0);
                armed             = 0;
                avm.m_waitrequest = 1'b0;
            end
        end
    end

    // Reference sequence: reload value first, then one step per tick.
    task automatic push_model(input int mode, input int pat, input int n);
        int s;
        bit left;
        s    = (mode == 0) ? 0 : pat;
        left = 1;
        for (int i = 0; i < n; i++) begin
            seq_q.push_back(s[7:0]);
            case (mode)
                0: s = 0;
                1: s = pat;
                2: s = ((s * 2) % 256) + (s / 128);
                default: begin
                    if (left) begin
                        s = (s * 2) % 256;
                        if (s >= 128) left = 0;
                    end else begin
                        s = s / 2;
                        if (s % 2 == 1) left = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic sw_write(input logic [7:0] d);
        int t;
        t = 0;
        sw_q.push_back(d);
        sw_data = d;
        sw_req  = 1'b1;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!sw_ack && t < 50);
        if (!sw_ack) fail("sw_ack_timeout", t, 50);
        sw_req = 1'b0;
    endtask

    task automatic wait_seq(input int n, input int budget);
        int t;
        t = 0;
        while (seq_done < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        enable = 1'b0;
        if (seq_done < n) fail("seq_timeout", seq_done, n);
    endtask

    task automatic sw_traffic(input int n);
        int guard;
        guard = 0;
        while (seq_done < n - 2 && guard < 50) begin
            guard++;
            repeat ($urandom_range(15, 3)) @(negedge clk);
            #1;
            if (seq_done < n - 2) sw_write(8'($urandom_range(255, 0)));
        end
    endtask

    task automatic run_phase(input int mode, input int pat, input int div,
                             input int n, input int stall,
                             input int period, input bit with_sw);
        cfg_mode     = 2'(mode);
        cfg_pattern  = 8'(pat);
        cfg_div      = DIV_W'(div);
        max_stall    = stall;
        exp_period   = period;
        prev_seq_cyc = -1;
        seq_done     = 0;
        push_model(mode, pat, n);
        @(negedge clk);
        #1;
        enable = 1'b1;
        fork
            wait_seq(n, n * (div + 14) + 40);
            begin
                if (with_sw) sw_traffic(n);
            end
        join
        exp_period = 0;
    endtask

    initial begin
        int t;
        int m;
        int pat;
        avm.m_waitrequest = 1'b0;

        #12;
        check_eq("rst_cs", {31'd0, avm.m_chipselect}, 32'd0);
        check_eq("rst_write_n", {31'd0, avm.m_write_n}, 32'd1);
        check_eq("rst_addr", {30'd0, avm.m_address}, {30'd0, PIO_ADDR});
        check_eq("rst_wdata", avm.m_writedata, 32'd0);
        check_eq("rst_ack", {31'd0, sw_ack}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_cur", {24'd0, cur_pattern}, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        // Rotate: 81, 03, 06 every 4 cycles.
        run_phase(2, 8'h81, 3, 3, 0, 4, 0);
        // Bounce from 01 out to 80 and back past 01.
        run_phase(3, 8'h01, 3, 17, 0, 4, 0);

        // Software request in the same cycle as a tick.
        cfg_mode    = 2'd1;
        cfg_pattern = 8'h5A;
        cfg_div     = DIV_W'(4);
        max_stall   = 0;
        seq_done    = 0;
        seq_q.push_back(8'h5A);
        @(negedge clk);
        #1;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        sw_write(8'hA5);
        wait_seq(1, 40);
        check_eq("arb_gap", last_seq_cyc - last_sw_cyc, 2);

`ifdef LED_SEQ_HOLD_EN
        cfg_pattern = 8'hC3;
        sw_write(8'h3C);
        @(negedge clk);
        #1;
        enable = 1'b1;
        repeat (110) @(negedge clk);
        #1;
        check_eq("hold_no_write", seq_done, 1);
        seq_done = 0;
        seq_q.push_back(8'hC3);
        sw_release = 1'b1;
        @(negedge clk);
        #1;
        sw_release = 1'b0;
        wait_seq(1, 40);
`endif

        // Long stall with a tick every cycle: one follow-up write.
        cfg_mode    = 2'd2;
        cfg_pattern = 8'h01;
        cfg_div     = '0;
        fixed_stall = 10;
        seq_done    = 0;
        seq_q.push_back(8'h01);
        seq_q.push_back(8'h20);
        @(negedge clk);
        #1;
        enable = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        enable = 1'b0;
        check_eq("stall_busy", {31'd0, busy}, 32'd1);
        wait_seq(2, 60);
        repeat (5) @(negedge clk);
        #1;
        check_eq("coalesce_count", seq_done, 2);
        fixed_stall = -1;

        for (int p = 0; p < 8; p++) begin
            m = $urandom_range(3, 0);
            do pat = $urandom_range(255, 0);
            while (pat == int'(cfg_pattern));
            run_phase(m, pat, $urandom_range(12, 8),
                      $urandom_range(12, 6), 1, 0, SW_MIX);
        end

        // Reset while a write is stalled drops the strobes at once.
        force_stall = 1;
        sw_data     = 8'h77;
        sw_req      = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!avm.m_chipselect && t < 20);
        if (!avm.m_chipselect) fail("stall_start_timeout", t, 20);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_cs", {31'd0, avm.m_chipselect}, 32'd0);
        check_eq("arst_write_n", {31'd0, avm.m_write_n}, 32'd1);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_wdata", avm.m_writedata, 32'd0);
        check_eq("arst_cur", {24'd0, cur_pattern}, 32'd0);
        check_eq("arst_ack", {31'd0, sw_ack}, 32'd0);
        sw_req      = 1'b0;
        force_stall = 0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;

        check_eq("sw_q_empty", sw_q.size(), 32'd0);
        check_eq("seq_q_empty", seq_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
